// File: rtl/e1ofn_pkg.sv
// Shared types and 1-of-N digit helpers for the clocked e1ofN merge.
// Digit helpers take a zero-extended rail vector plus the rail/digit counts.
package e1ofn_pkg;

  localparam int TAG_RAILS  = 2;
  localparam int MAX_BITS   = 64;
  localparam int MAX_DIGITS = 16;

  typedef enum logic [1:0] {RX_EMPTY, RX_FULL, RX_NEUTRAL} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_DRIVE, TX_RTZ} tx_state_t;

  function automatic logic [MAX_BITS-1:0] rail_mask(input int n);
    return ~({MAX_BITS{1'b1}} << n);
  endfunction

  function automatic int digit_ones(input logic [MAX_BITS-1:0] d, input int n, input int k);
    return $countones((d >> (k * n)) & rail_mask(n));
  endfunction

  function automatic logic is_valid(input logic [MAX_BITS-1:0] d, input int n, input int m);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (k < m && digit_ones(d, n, k) != 1) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic multi_hot(input logic [MAX_BITS-1:0] d, input int n, input int m);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (k < m && digit_ones(d, n, k) > 1) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic is_neutral(input logic [MAX_BITS-1:0] d, input int n, input int m);
    return (d & rail_mask(n * m)) == '0;
  endfunction

endpackage

// File: rtl/e1ofn_sync_rx.sv
// One merge input: synchroniser chain on the rails, capture FSM and token hold register.
// The enable is registered so it only moves on a clock edge.
module e1ofn_sync_rx
  import e1ofn_pkg::*;
#(
  parameter int N    = 2,
  parameter int M    = 1,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*M-1:0] rails,
  input  logic           grant,
  output logic           e,
  output logic           full,
  output logic [N*M-1:0] hold
);

  localparam int W = N * M;

  logic [SYNC-1:0][W-1:0] sync_q;
  logic [W-1:0]           synced;
  logic [MAX_BITS-1:0]    synced_ext;
  rx_state_t              state_q, state_d;
  logic                   capture, err_set, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC-2:0], rails};
  end

  assign synced = sync_q[SYNC-1];

  // A multi-hot digit is never captured; the channel waits for a clean token.
  always_comb begin
    synced_ext         = '0;
    synced_ext[W-1:0]  = synced;
    state_d            = state_q;
    capture            = 1'b0;
    err_set            = 1'b0;
    case (state_q)
      RX_EMPTY: begin
        if (multi_hot(synced_ext, N, M)) begin
          err_set = 1'b1;
        end else if (is_valid(synced_ext, N, M)) begin
          capture = 1'b1;
          state_d = RX_FULL;
        end
      end
      RX_FULL:    if (grant) state_d = RX_NEUTRAL;
      RX_NEUTRAL: if (is_neutral(synced_ext, N, M)) state_d = RX_EMPTY;
      default:    state_d = RX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_EMPTY;
      e       <= 1'b1;
      hold    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e       <= (state_d == RX_EMPTY);
      if (capture) hold  <= synced;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign full = (state_q == RX_FULL);

  cover property (@(posedge clk) err_q);

endmodule

// File: rtl/special_merge_sync.sv
// Clocked 2:1 e1ofN merge: two synchronised input channels, round-robin arbiter and
// a registered output token with an optional 1-of-N source-tag digit on top.
module special_merge_sync
  import e1ofn_pkg::*;
#(
  parameter int N    = 2,
  parameter int M    = 1,
  parameter int TAG  = 1,
  parameter int SYNC = 2
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  input  logic [N*M-1:0]       In0_d,
  output logic                 In0_e,
  input  logic [N*M-1:0]       In1_d,
  output logic                 In1_e,
  output logic [N*(M+TAG)-1:0] Out_d,
  input  logic                 Out_e
);

  localparam int W_IN  = N * M;
  localparam int W_OUT = N * (M + TAG);

  logic              full0, full1, grant0, grant1;
  logic [W_IN-1:0]   hold0, hold1, pick_hold;
  logic [SYNC-1:0]   oe_sync_q;
  logic              out_e_s, pick, rr_q, rr_d;
  logic [N-1:0]      tag_digit;
  logic [W_OUT-1:0]  token, out_q, out_d;
  tx_state_t         tx_q, tx_d;

  e1ofn_sync_rx #(.N(N), .M(M), .SYNC(SYNC)) u_rx0 (
    .clk(CLK), .rst_n(_RESET), .rails(In0_d), .grant(grant0),
    .e(In0_e), .full(full0), .hold(hold0)
  );

  e1ofn_sync_rx #(.N(N), .M(M), .SYNC(SYNC)) u_rx1 (
    .clk(CLK), .rst_n(_RESET), .rails(In1_d), .grant(grant1),
    .e(In1_e), .full(full1), .hold(hold1)
  );

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) oe_sync_q <= '0;
    else         oe_sync_q <= {oe_sync_q[SYNC-2:0], Out_e};
  end

  assign out_e_s = oe_sync_q[SYNC-1];

  // The pointer only moves on a contested grant, so a lone requester never steals priority.
  always_comb begin
    tx_d      = tx_q;
    out_d     = out_q;
    rr_d      = rr_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    pick      = (full0 && full1) ? rr_q : full1;
    pick_hold = pick ? hold1 : hold0;
    tag_digit = pick ? N'(2) : N'(1);
    token     = '0;
    token[W_IN-1:0] = pick_hold;
    if (TAG != 0) token[W_OUT-1 -: N] = tag_digit;
    case (tx_q)
      TX_IDLE: begin
        if (out_e_s && (full0 || full1)) begin
          grant0 = !pick;
          grant1 = pick;
          out_d  = token;
          if (full0 && full1) rr_d = !pick;
          tx_d   = TX_DRIVE;
        end
      end
      TX_DRIVE: begin
        if (!out_e_s) begin
          out_d = '0;
          tx_d  = TX_RTZ;
        end
      end
      TX_RTZ:  if (out_e_s) tx_d = TX_IDLE;
      default: begin
        out_d = '0;
        tx_d  = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      tx_q  <= TX_IDLE;
      out_q <= '0;
      rr_q  <= 1'b0;
    end else begin
      tx_q  <= tx_d;
      out_q <= out_d;
      rr_q  <= rr_d;
    end
  end

  assign Out_d = out_q;

endmodule

// File: tb/tb_special_merge_sync.sv
// Directed bench for special_merge_sync (N=2, M=1, TAG=1, SYNC=2): vector table
// plus hand-written latency, back-pressure, illegal-token and mid-handshake reset sequences.
module tb_special_merge_sync;

  localparam int N = 2, M = 1, TAG = 1, SYNC = 2;
  localparam int BOUND = 1000;

  logic       CLK = 1'b0;
  logic       _RESET;
  logic [1:0] In0_d, In1_d;
  logic       In0_e, In1_e;
  logic [3:0] Out_d;
  logic       Out_e;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [1:0] d0;
    logic [1:0] d1;
    bit         use0;
    bit         use1;
    logic [3:0] expFirst;
    logic [3:0] expSecond;
  } vector_t;

  vector_t    vecs[7];
  logic [1:0] send0[$], send1[$], exp0[$], exp1[$];

  special_merge_sync #(.N(N), .M(M), .TAG(TAG), .SYNC(SYNC)) dut (
    .CLK(CLK), ._RESET(_RESET),
    .In0_d(In0_d), .In0_e(In0_e),
    .In1_d(In1_d), .In1_e(In1_e),
    .Out_d(Out_d), .Out_e(Out_e)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: timeout after %0d cycles", name, BOUND);
  endtask

  task automatic waitOut(input string name);
    for (int i = 0; i < BOUND; i++) begin
      if (Out_d != 4'b0000) break;
      @(negedge CLK);
    end
    if (Out_d == 4'b0000) timeoutFail(name);
  endtask

  task automatic waitZero(input string name);
    for (int i = 0; i < BOUND; i++) begin
      if (Out_d == 4'b0000) break;
      @(negedge CLK);
    end
    if (Out_d != 4'b0000) timeoutFail(name);
  endtask

  task automatic waitE(input string name, input bit which, input logic value);
    for (int i = 0; i < BOUND; i++) begin
      if ((which ? In1_e : In0_e) === value) break;
      @(negedge CLK);
    end
    if ((which ? In1_e : In0_e) !== value) timeoutFail(name);
  endtask

  task automatic handshakeOut(input string name);
    Out_e = 1'b0;
    waitZero({name, " rtz"});
    Out_e = 1'b1;
    @(negedge CLK);
  endtask

  // One table entry: drive the used inputs together, then accept one or two output tokens.
  task automatic applyStimulus(input vector_t v, input string name);
    if (v.use0) In0_d = v.d0;
    if (v.use1) In1_d = v.d1;
    waitOut({name, " first wait"});
    checkOutput({name, " first"}, Out_d, v.expFirst);
    @(negedge CLK);
    checkOutput({name, " first stable"}, Out_d, v.expFirst);
    if (v.use0) checkOutput({name, " In0_e low"}, {3'b000, In0_e}, 4'b0000);
    if (v.use1) checkOutput({name, " In1_e low"}, {3'b000, In1_e}, 4'b0000);
    In0_d = 2'b00;
    In1_d = 2'b00;
    handshakeOut({name, " first"});
    if (v.use0 && v.use1) begin
      waitOut({name, " second wait"});
      checkOutput({name, " second"}, Out_d, v.expSecond);
      handshakeOut({name, " second"});
    end
    waitE({name, " In0_e wait"}, 1'b0, 1'b1);
    waitE({name, " In1_e wait"}, 1'b1, 1'b1);
    checkOutput({name, " In0_e high"}, {3'b000, In0_e}, 4'b0001);
    checkOutput({name, " In1_e high"}, {3'b000, In1_e}, 4'b0001);
  endtask

  task automatic sendStream(input bit which);
    for (int i = 0; i < 6; i++) begin
      if (which) In1_d = send1[i];
      else       In0_d = send0[i];
      waitE("bp capture", which, 1'b0);
      if (which) In1_d = 2'b00;
      else       In0_d = 2'b00;
      waitE("bp release", which, 1'b1);
    end
  endtask

  initial begin
    vector_t v;
    logic [1:0] t;

    // Expected tokens trace the round-robin pointer from reset through the table.
    vecs[0] = '{d0: 2'b01, d1: 2'b10, use0: 1, use1: 1, expFirst: 4'b0101, expSecond: 4'b1010};
    vecs[1] = '{d0: 2'b10, d1: 2'b01, use0: 1, use1: 1, expFirst: 4'b1001, expSecond: 4'b0110};
    vecs[2] = '{d0: 2'b00, d1: 2'b01, use0: 0, use1: 1, expFirst: 4'b1001, expSecond: 4'b0000};
    vecs[3] = '{d0: 2'b01, d1: 2'b01, use0: 1, use1: 1, expFirst: 4'b0101, expSecond: 4'b1001};
    vecs[4] = '{d0: 2'b10, d1: 2'b00, use0: 1, use1: 0, expFirst: 4'b0110, expSecond: 4'b0000};
    vecs[5] = '{d0: 2'b10, d1: 2'b10, use0: 1, use1: 1, expFirst: 4'b1010, expSecond: 4'b0110};
    vecs[6] = '{d0: 2'b00, d1: 2'b10, use0: 0, use1: 1, expFirst: 4'b1010, expSecond: 4'b0000};

    _RESET = 1'b0;
    In0_d  = 2'b00;
    In1_d  = 2'b00;
    Out_e  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #100;
      checkOutput("reset In0_e", {3'b000, In0_e}, 4'b0001);
      checkOutput("reset In1_e", {3'b000, In1_e}, 4'b0001);
      checkOutput("reset Out_d", Out_d, 4'b0000);
    end
    @(negedge CLK);
    _RESET = 1'b1;
    repeat (4) @(negedge CLK);

    // Single token with exact capture latency: e falls SYNC+1 edges after the rails.
    In0_d = 2'b10;
    repeat (SYNC) @(negedge CLK);
    checkOutput("latency e still high", {3'b000, In0_e}, 4'b0001);
    @(negedge CLK);
    checkOutput("latency e fall", {3'b000, In0_e}, 4'b0000);
    checkOutput("latency out not yet", Out_d, 4'b0000);
    @(negedge CLK);
    checkOutput("single token out", Out_d, 4'b0110);
    In0_d = 2'b00;
    handshakeOut("single");
    checkOutput("single rtz", Out_d, 4'b0000);
    waitE("single e return", 1'b0, 1'b1);
    checkOutput("single e return", {3'b000, In0_e}, 4'b0001);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      applyStimulus(v, $sformatf("vec%0d", i));
    end

    // Back-pressure: receiver stalls, both sides queue six tokens each.
    for (int i = 0; i < 6; i++) begin
      t = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      send0.push_back(t);
      exp0.push_back(t);
      t = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      send1.push_back(t);
      exp1.push_back(t);
    end
    Out_e = 1'b0;
    repeat (SYNC + 1) @(negedge CLK);
    fork
      sendStream(1'b0);
      sendStream(1'b1);
      begin
        repeat (50) @(negedge CLK);
        checkOutput("bp stall Out_d", Out_d, 4'b0000);
        checkOutput("bp stall In0_e", {3'b000, In0_e}, 4'b0000);
        checkOutput("bp stall In1_e", {3'b000, In1_e}, 4'b0000);
        Out_e = 1'b1;
        for (int i = 0; i < 12; i++) begin
          waitOut("bp token wait");
          if (Out_d[3:2] == 2'b01 && exp0.size() > 0)
            checkOutput("bp In0 order", {2'b00, Out_d[1:0]}, {2'b00, exp0.pop_front()});
          else if (Out_d[3:2] == 2'b10 && exp1.size() > 0)
            checkOutput("bp In1 order", {2'b00, Out_d[1:0]}, {2'b00, exp1.pop_front()});
          else
            checkOutput("bp unexpected token", Out_d, 4'b0000);
          handshakeOut("bp");
        end
      end
    join
    checkOutput("bp In0 left", 4'(exp0.size()), 4'd0);
    checkOutput("bp In1 left", 4'(exp1.size()), 4'd0);

    // Illegal multi-hot digit: no capture, sticky error, then a clean token.
    checkOutput("err before", {3'b000, dut.u_rx0.err_q}, 4'b0000);
    In0_d = 2'b11;
    repeat (6) @(negedge CLK);
    checkOutput("illegal no capture", {3'b000, In0_e}, 4'b0001);
    checkOutput("illegal no output", Out_d, 4'b0000);
    checkOutput("illegal err_q", {3'b000, dut.u_rx0.err_q}, 4'b0001);
    checkOutput("illegal other err_q", {3'b000, dut.u_rx1.err_q}, 4'b0000);
    In0_d = 2'b00;
    repeat (4) @(negedge CLK);
    v = '{d0: 2'b01, d1: 2'b00, use0: 1, use1: 0, expFirst: 4'b0101, expSecond: 4'b0000};
    applyStimulus(v, "after illegal");
    checkOutput("err sticky", {3'b000, dut.u_rx0.err_q}, 4'b0001);

    // Reset while a token is being driven drops it asynchronously.
    In0_d = 2'b10;
    waitOut("midreset wait");
    checkOutput("midreset drive", Out_d, 4'b0110);
    #2;
    _RESET = 1'b0;
    #1;
    checkOutput("midreset Out_d", Out_d, 4'b0000);
    checkOutput("midreset In0_e", {3'b000, In0_e}, 4'b0001);
    checkOutput("midreset In1_e", {3'b000, In1_e}, 4'b0001);
    In0_d = 2'b00;
    Out_e = 1'b1;
    repeat (3) @(negedge CLK);
    _RESET = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("post reset idle", Out_d, 4'b0000);
    v = '{d0: 2'b01, d1: 2'b10, use0: 1, use1: 1, expFirst: 4'b0101, expSecond: 4'b1010};
    applyStimulus(v, "post reset collision");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
